cntr_dn_tmr: RTL and testbench

Loadable down-counter/timer; the counting-down counterpart to the team's free-running up-counters.
- A producer loads a start value over a valid/ready handshake.
- The block decrements on each clock-enable strobe and emits a one-cycle terminal-count pulse when it reaches zero.
- Used as a programmable delay/interval timer next to the clock-enable prescalers in the lab designs.

---
 rtl/cntr_dn_tmr.sv | 102 ++++++++++
 tb/tb_cntr_dn_tmr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_dn_tmr.sv
// Loadable down-counter/timer: valid/ready load, decrement on ce, one-cycle tc at zero.
// Optional periodic mode with `define CNTR_DN_AUTO_RELOAD_EN (DONE reloads the start value).
module cntr_dn_tmr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    output logic             ld_ready,
    input  logic             abort,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
`ifdef CNTR_DN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
`ifdef CNTR_DN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
`ifdef CNTR_DN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
`ifdef CNTR_DN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    cnt_d    = ld_data;
`ifdef CNTR_DN_AUTO_RELOAD_EN
                    reload_d = ld_data;
`endif
                    state_d  = (ld_data == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // abort wins over ce; leaving RUN at 1->0 means the count never wraps
                if (abort) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (ce) begin
                    cnt_d = cnt_q - WIDTH'(1);
                    if (cnt_q == WIDTH'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
`ifdef CNTR_DN_AUTO_RELOAD_EN
                if (abort) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (reload_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = reload_q;
                    state_d = S_RUN;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Every output comes straight from a register: no input-to-output path.
    assign out      = cnt_q;
    assign ld_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_RUN);
    assign tc       = (state_q == S_DONE);

endmodule

// File: tb/tb_cntr_dn_tmr.sv
// Directed bench for cntr_dn_tmr (WIDTH=8); the periodic-mode scenario builds only
// when CNTR_DN_AUTO_RELOAD_EN is defined.
module tb_cntr_dn_tmr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ce = 1'b0;
    logic         ld_valid = 1'b0;
    logic [W-1:0] ld_data = '0;
    logic         ld_ready;
    logic         abort = 1'b0;
    logic [W-1:0] out;
    logic         busy;
    logic         tc;

    int n_checks = 0;
    int n_errors = 0;

    cntr_dn_tmr #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .abort    (abort),
        .out      (out),
        .busy     (busy),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        ld_valid = 1'b1;
        ld_data  = v;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+2:0] exp_v;
        #2;
        exp_v = {8'd0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL reset_init: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        tick();
        rst = 1'b1;
        tick();
        do_load(8'd5);
        exp_v = {8'd5, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL reset_preload: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        // assert reset mid-cycle, well away from any clk edge
        #2;
        rst = 1'b0;
        #1;
        exp_v = {8'd0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL reset_async: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_count();
        logic [W+2:0] exp_v;
        ce = 1'b1;
        do_load(8'd5);
        exp_v = {8'd5, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL count_load: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_v = {8'(5 - i), (i < 5), (i == 5), 1'b0};
            n_checks++;
            if ({out, busy, tc, ld_ready} !== exp_v) begin
                n_errors++;
                $display("FAIL count_step%0d: got %h expected %h", i, {out, busy, tc, ld_ready}, exp_v);
            end
        end
        tick();
        exp_v = {8'd0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL count_idle: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        ce = 1'b0;
    endtask

    task automatic test_ce_strobe();
        logic [W-1:0] exp_cnt;
        logic [W+1:0] exp_v;
        ce = 1'b0;
        do_load(8'd3);
        exp_cnt = 8'd3;
        for (int c = 1; c <= 12; c++) begin
            ce = (c % 4 == 0);
            tick();
            if (c % 4 == 0) exp_cnt = exp_cnt - 8'd1;
            ce = 1'b0;
            exp_v = {exp_cnt, (exp_cnt != 0), (exp_cnt == 0)};
            n_checks++;
            if ({out, busy, tc} !== exp_v) begin
                n_errors++;
                $display("FAIL strobe_c%0d: got %h expected %h", c, {out, busy, tc}, exp_v);
            end
        end
        tick();
        n_checks++;
        if ({tc, ld_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL strobe_after: got %b expected 01", {tc, ld_ready});
        end
    endtask

    task automatic test_load_zero();
        logic [W+2:0] exp_v;
        ce = 1'b1;
        do_load(8'd0);
        exp_v = {8'd0, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL zero_done: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        tick();
        exp_v = {8'd0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL zero_idle: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        ce = 1'b0;
    endtask

    task automatic test_abort();
        logic [W+2:0] exp_v;
        ce = 1'b1;
        do_load(8'd10);
        tick();
        ld_valid = 1'b1;
        ld_data  = 8'd55;
        tick();
        ld_valid = 1'b0;
        n_checks++;
        if (out !== 8'd8) begin
            n_errors++;
            $display("FAIL abort_ldignored: got %0d expected 8", out);
        end
        tick();
        n_checks++;
        if (out !== 8'd7) begin
            n_errors++;
            $display("FAIL abort_pre: got %0d expected 7", out);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_v = {8'd0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if ({out, busy, tc, ld_ready} !== exp_v) begin
            n_errors++;
            $display("FAIL abort_idle: got %h expected %h", {out, busy, tc, ld_ready}, exp_v);
        end
        tick();
        n_checks++;
        if ({out, tc} !== {8'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL abort_notc: got %h expected 000", {out, tc});
        end
        // abort while IDLE must not block a load
        abort = 1'b1;
        do_load(8'd4);
        abort = 1'b0;
        n_checks++;
        if ({out, busy} !== {8'd4, 1'b1}) begin
            n_errors++;
            $display("FAIL abort_inidle: got %h expected %h", {out, busy}, {8'd4, 1'b1});
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ce = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] exp_seq [5];
        ce = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'd2;
        exp_seq[0] = {8'd2, 1'b1, 1'b0, 1'b0};
        exp_seq[1] = {8'd1, 1'b1, 1'b0, 1'b0};
        exp_seq[2] = {8'd0, 1'b0, 1'b1, 1'b0};
        exp_seq[3] = {8'd0, 1'b0, 1'b0, 1'b1};
        exp_seq[4] = {8'd2, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if ({out, busy, tc, ld_ready} !== exp_seq[i]) begin
                n_errors++;
                $display("FAIL b2b_c%0d: got %h expected %h", i, {out, busy, tc, ld_ready}, exp_seq[i]);
            end
        end
        ld_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ce = 1'b0;
    endtask

`ifdef CNTR_DN_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [W+2:0] exp_seq [3];
        ce = 1'b1;
        do_load(8'd2);
        exp_seq[0] = {8'd1, 1'b1, 1'b0, 1'b0};
        exp_seq[1] = {8'd0, 1'b0, 1'b1, 1'b0};
        exp_seq[2] = {8'd2, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            tick();
            n_checks++;
            if ({out, busy, tc, ld_ready} !== exp_seq[i % 3]) begin
                n_errors++;
                $display("FAIL reload_c%0d: got %h expected %h", i, {out, busy, tc, ld_ready}, exp_seq[i % 3]);
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({out, busy, tc, ld_ready} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL reload_abort: got %h expected 001", {out, busy, tc, ld_ready});
        end
        ce = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_ce_strobe();
        test_load_zero();
        test_abort();
        test_back_to_back();
`ifdef CNTR_DN_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
